// File: rtl/decode_stage.sv
// RV32 decode stage: one-entry registered output slot with valid/ready handshakes on both sides.
// Define LOAD_USE_STALL_EN to compile in load-use hazard detection (inserts exactly one bubble).
package decode_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_NDEF = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic    branch;
        logic    branch_neq;
        logic    jump;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_write;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JUMP  = 7'b1101111;

    localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_NDEF};

    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt, input logic sub_ok);
        case (f3)
            3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

module decode_stage #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [11:0]     out_ctrl,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
);
    import decode_pkg::*;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1, w_rs2, w_rd_f, w_rd;
    logic [2:0]  w_f3;
    logic        w_alt, w_illegal, w_hazard, w_xfer;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm;
    ctrl_t       w_ctrl;

    logic            r_valid, r_illegal;
    ctrl_t           r_ctrl;
    logic [31:0]     r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [2:0]      r_f3;
    logic [PC_W-1:0] r_pc;

    assign w_opcode = in_insn[6:0];
    assign w_rd_f   = in_insn[11:7];
    assign w_f3     = in_insn[14:12];
    assign w_rs1    = in_insn[19:15];
    assign w_rs2    = in_insn[24:20];
    assign w_alt    = in_insn[30];

    assign w_imm_i = {{20{in_insn[31]}}, in_insn[31:20]};
    assign w_imm_s = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
    assign w_imm_b = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
    assign w_imm_j = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_ctrl    = CTRL_NOP;
        w_imm     = '0;
        w_rd      = w_rd_f;
        w_illegal = 1'b0;
        case (w_opcode)
            OP_REG: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = alu_from_f3(w_f3, w_alt, 1'b1);
            end
            OP_IMM: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = alu_from_f3(w_f3, w_alt, 1'b0);
                w_imm            = w_imm_i;
            end
            OP_LOAD: begin
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_op     = ALU_ADD;
                w_imm             = w_imm_i;
            end
            OP_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
                w_imm            = w_imm_s;
                w_rd             = '0;
            end
            OP_BR: begin
                w_rd = '0;
                // Only beq/bne are decoded; other branch conditions trap as illegal.
                if (w_f3[2:1] == 2'b00) begin
                    w_ctrl.branch     = 1'b1;
                    w_ctrl.branch_neq = w_f3[0];
                    w_ctrl.alu_op     = ALU_SUB;
                    w_imm             = w_imm_b;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_JUMP: begin
                w_ctrl.jump      = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
                w_imm            = w_imm_j;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_rd == 5'd0) w_ctrl.reg_write = 1'b0;
    end

`ifdef LOAD_USE_STALL_EN
    logic w_rs1_used, w_rs2_used;
    always_comb begin
        w_rs1_used = (w_opcode != OP_JUMP);
        w_rs2_used = (w_opcode == OP_REG) || (w_opcode == OP_STORE) || (w_opcode == OP_BR);
        w_hazard   = in_valid && r_valid && r_ctrl.mem_read && (r_rd != 5'd0) &&
                     ((w_rs1_used && (w_rs1 == r_rd)) || (w_rs2_used && (w_rs2 == r_rd)));
    end
`else
    assign w_hazard = 1'b0;
`endif

    assign in_ready = (!r_valid || out_ready) && !w_hazard && !flush && !rst;
    assign w_xfer   = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctrl    <= CTRL_NOP;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_f3      <= '0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid   <= 1'b1;
            r_ctrl    <= w_ctrl;
            r_imm     <= w_imm;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_f3      <= w_f3;
            r_pc      <= in_pc;
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            // Drained with nothing new (or a load-use bubble): slot goes empty.
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_ctrl    = r_ctrl;
    assign out_imm     = r_imm;
    assign out_rs1     = r_rs1;
    assign out_rs2     = r_rs2;
    assign out_rd      = r_rd;
    assign out_funct3  = r_f3;
    assign out_pc      = r_pc;
    assign out_illegal = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table-driven decode vectors plus directed
// sequences for back-pressure, flush, drain, load-use and reset-mid-stall.
module tb_decode_stage;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_ctrl;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [31:0] out_pc;
    logic        out_illegal;

    decode_stage #(.PC_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [11:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        ill;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t v, input logic [31:0] pc);
        check({tag, " valid"},   32'(out_valid),   32'd1);
        check({tag, " ctrl"},    32'(out_ctrl),    32'(v.ctrl));
        check({tag, " imm"},     out_imm,          v.imm);
        check({tag, " rs1"},     32'(out_rs1),     32'(v.rs1));
        check({tag, " rs2"},     32'(out_rs2),     32'(v.rs2));
        check({tag, " rd"},      32'(out_rd),      32'(v.rd));
        check({tag, " funct3"},  32'(out_funct3),  32'(v.f3));
        check({tag, " illegal"}, 32'(out_illegal), 32'(v.ill));
        check({tag, " pc"},      out_pc,           pc);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " valid"},   32'(out_valid),   32'd0);
        check({tag, " ctrl"},    32'(out_ctrl),    32'h00F);
        check({tag, " imm"},     out_imm,          32'd0);
        check({tag, " rs1"},     32'(out_rs1),     32'd0);
        check({tag, " rs2"},     32'(out_rs2),     32'd0);
        check({tag, " rd"},      32'(out_rd),      32'd0);
        check({tag, " funct3"},  32'(out_funct3),  32'd0);
        check({tag, " pc"},      out_pc,           32'd0);
        check({tag, " illegal"}, 32'(out_illegal), 32'd0);
    endtask

    initial begin
        // ctrl = {branch, bneq, jump, mem_read, mem_write, mem_to_reg, reg_write, alu_src, alu_op[3:0]}
        vecs[0]  = '{32'h002081B3, 12'h020, 32'h0000_0000, 5'd1, 5'd2,  5'd3, 3'd0, 1'b0}; // add x3,x1,x2
        vecs[1]  = '{32'h402081B3, 12'h021, 32'h0000_0000, 5'd1, 5'd2,  5'd3, 3'd0, 1'b0}; // sub x3,x1,x2
        vecs[2]  = '{32'hFE209EE3, 12'hC01, 32'hFFFF_FFFC, 5'd1, 5'd2,  5'd0, 3'd1, 1'b0}; // bne x1,x2,-4
        vecs[3]  = '{32'h00000000, 12'h00F, 32'h0000_0000, 5'd0, 5'd0,  5'd0, 3'd0, 1'b1}; // all-zero word
        vecs[4]  = '{32'hFFF08293, 12'h030, 32'hFFFF_FFFF, 5'd1, 5'd31, 5'd5, 3'd0, 1'b0}; // addi x5,x1,-1
        vecs[5]  = '{32'h4030D293, 12'h037, 32'h0000_0403, 5'd1, 5'd3,  5'd5, 3'd5, 1'b0}; // srai x5,x1,3
        vecs[6]  = '{32'h0000A283, 12'h170, 32'h0000_0000, 5'd1, 5'd0,  5'd5, 3'd2, 1'b0}; // lw x5,0(x1)
        vecs[7]  = '{32'h0020A423, 12'h090, 32'h0000_0008, 5'd1, 5'd2,  5'd0, 3'd2, 1'b0}; // sw x2,8(x1)
        vecs[8]  = '{32'h008000EF, 12'h220, 32'h0000_0008, 5'd0, 5'd8,  5'd1, 3'd0, 1'b0}; // jal x1,8
        vecs[9]  = '{32'h00208033, 12'h000, 32'h0000_0000, 5'd1, 5'd2,  5'd0, 3'd0, 1'b0}; // add x0: no write
        vecs[10] = '{32'hFE20CEE3, 12'h00F, 32'h0000_0000, 5'd1, 5'd2,  5'd0, 3'd4, 1'b1}; // branch f3=100
        vecs[11] = '{32'h000080E7, 12'h00F, 32'h0000_0000, 5'd1, 5'd0,  5'd1, 3'd0, 1'b1}; // jalr opcode
        vecs[12] = '{32'h0020B1B3, 12'h024, 32'h0000_0000, 5'd1, 5'd2,  5'd3, 3'd3, 1'b0}; // sltu x3,x1,x2

        rst = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_insn = 32'h002081B3; in_pc = 32'hDEAD_0000;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        step();
        check_reset_state("reset");
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        // Decode table, one instruction per cycle with the sink always ready.
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_insn  = vecs[i].insn;
            in_pc    = 32'h1000 + 32'(i) * 4;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            step();
            check_vec($sformatf("vec%0d", i), vecs[i], 32'h1000 + 32'(i) * 4);
        end

        // Drain: sink takes the last one, nothing new arrives.
        in_valid = 1'b0;
        step();
        check("drain valid", 32'(out_valid), 32'd0);

        // Back-pressure for three cycles, release on the fourth.
        in_valid = 1'b1; in_insn = vecs[0].insn; in_pc = 32'h2000;
        step();
        check_vec("bp load", vecs[0], 32'h2000);
        out_ready = 1'b0;
        in_insn = vecs[1].insn; in_pc = 32'h2004;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            step();
            check_vec($sformatf("bp%0d hold", k), vecs[0], 32'h2000);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        check_vec("bp release", vecs[1], 32'h2004);

        // Flush with a held instruction and a valid incoming one.
        in_insn = vecs[4].insn; in_pc = 32'h3000; flush = 1'b1;
        #1;
        check("flush in_ready", 32'(in_ready), 32'd0);
        step();
        check("flush valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush no consume valid", 32'(out_valid), 32'd0);
        check("flush no consume pc", out_pc, 32'h2004);

        // Load followed by a dependent add.
        in_valid = 1'b1; in_insn = 32'h0000A283; in_pc = 32'h4000;
        step();
        check("lu load ctrl", 32'(out_ctrl), 32'h170);
        in_insn = 32'h00728333; in_pc = 32'h4004;
        #1;
`ifdef LOAD_USE_STALL_EN
        check("lu stall in_ready", 32'(in_ready), 32'd0);
        step();
        check("lu bubble valid", 32'(out_valid), 32'd0);
        check("lu after bubble in_ready", 32'(in_ready), 32'd1);
        step();
`else
        check("lu no stall in_ready", 32'(in_ready), 32'd1);
        step();
`endif
        check("lu add valid", 32'(out_valid), 32'd1);
        check("lu add ctrl", 32'(out_ctrl), 32'h020);
        check("lu add rd", 32'(out_rd), 32'd6);
        check("lu add pc", out_pc, 32'h4004);
        in_valid = 1'b0;
        step();

        // Reset while stalled discards the held instruction.
        in_valid = 1'b1; in_insn = vecs[12].insn; in_pc = 32'h5000;
        step();
        out_ready = 1'b0; in_insn = vecs[0].insn; in_pc = 32'h5004;
        step();
        check("rs held valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rs in_ready", 32'(in_ready), 32'd0);
        step();
        check_reset_state("rs");
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("rs after valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, instruction-address width of in_pc/out_pc.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: fetch-side handshake; transfer when both high at a clock edge.
REQ-005 SHALL have ports in_insn input 32 and in_pc input PC_W: instruction word and its address.
REQ-006 SHALL have port flush input 1: discard held and incoming instruction (branch/jump taken downstream).
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1: execute-side handshake.
REQ-008 SHALL have port out_ctrl output 12: control word packed as {branch, branch_neq, jump, mem_read, mem_write, mem_to_reg, reg_write, alu_src, alu_op[3:0]} with the codebase aluop encoding.
REQ-009 SHALL have outputs out_imm 32, out_rs1 5, out_rs2 5, out_rd 5, out_funct3 3, out_pc PC_W, out_illegal 1.

Function
REQ-010 SHALL hold one decoded instruction in an output register; all out_* are registered, with no combinational in->out path.
REQ-011 SHALL compute in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-012 On transfer, SHALL load the output register next edge with out_valid=1; latency is 1 cycle.
REQ-013 If out_valid && out_ready && no new transfer, SHALL clear out_valid next edge.
REQ-014 If out_valid && !out_ready, SHALL hold all out_* stable.
REQ-015 op_reg: reg_write=1; alu_op from funct3 (add/sll/slt/sltu/xor/sr/or/and); funct7[5]=1 selects alu_sub for add and alu_sra for sr; out_imm=0.
REQ-016 op_imm: reg_write=1, alu_src=1, I-imm sign-extended; sr uses funct7[5] for sra; add never becomes sub.
REQ-017 op_load: mem_read, mem_to_reg, reg_write, alu_src=1, alu_add, I-imm.
REQ-018 op_store: mem_write, alu_src=1, alu_add, S-imm; out_rd driven as 0.
REQ-019 op_br: branch=1, alu_sub, B-imm (bit0=0); funct3=001 sets branch_neq; funct3 other than 000/001 is illegal; out_rd=0.
REQ-020 op_jump: jump=1, reg_write=1, alu_add, J-imm (bit0=0).
REQ-021 Any other opcode, or illegal funct3 per REQ-019, SHALL yield out_illegal=1, all control bits 0, alu_op=alu_ndef.
REQ-022 reg_write SHALL be forced 0 when rd=0.
REQ-023 flush SHALL clear out_valid next edge and block acceptance that cycle; flush has priority over every other event.

Reset
REQ-024 While rst is high at an edge, out_valid=0, out_ctrl=0 except alu_op=alu_ndef, out_imm/out_rs1/out_rs2/out_rd/out_funct3/out_pc=0, out_illegal=0.
REQ-025 in_ready SHALL be 0 during any cycle rst is high; an instruction presented mid-reset is dropped.
REQ-026 Reset mid-stall SHALL discard the held instruction and any pending bubble.

Configuration
REQ-027 Macro LOAD_USE_STALL_EN SHALL compile in load-use hazard detection.
REQ-028 With it: hazard = out_valid && mem_read && out_rd!=0 && (in_rs1==out_rd where rs1 is used [all except op_jump] || in_rs2==out_rd where rs2 is used [op_reg/op_store/op_br]), with in_valid=1.
REQ-029 With it: on hazard && out_ready, register a bubble (out_valid=0) next edge; the instruction is accepted the following cycle (exactly one bubble).
REQ-030 Without it: hazard is constant 0; no bubbles are inserted.

Verification
REQ-031 After rst, in 0x002081B3 (add x3,x1,x2) with out_ready=1 -> next cycle out_valid=1, reg_write=1, alu_op=alu_add, rs1=1, rs2=2, rd=3.
REQ-032 0x402081B3 -> alu_sub; 0xFE209EE3 (bne x1,x2,-4) -> branch=1, branch_neq=1, out_imm=0xFFFFFFFC, out_rd=0.
REQ-033 With LOAD_USE_STALL_EN: 0x0000A283 (lw x5) then 0x00728333 (add x6,x5,x7) back-to-back -> in_ready=0 for one cycle, one out_valid=0 bubble, then add issued; without the macro, no bubble.
REQ-034 out_ready=0 for 3 cycles with a valid instruction held -> out_* unchanged and in_ready=0 throughout; releases on the 4th.
REQ-035 0x00000000 -> out_illegal=1, control 0, alu_op=alu_ndef; flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle and the input is not consumed.
